// File: rtl/surfctl_eye_scan_master.sv
// Eye-scan Wishbone initiator: sweeps the link IDELAY, measures bit errors per tap,
// then programs the centre of the longest error-free window back into the IDELAY.
module surfctl_eye_scan_master #(
  parameter logic [5:0] IDELAY_ADR = 6'h04,
  parameter logic [5:0] BITERR_ADR = 6'h08,
  parameter int         MAX_TAP    = 63,
  parameter int         TIMEOUT    = 1023
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic [23:0] interval_i,
  input  logic [23:0] dwell_i,
  input  logic [24:0] thresh_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic        res_valid_o,
  output logic [5:0]  res_tap_o,
  output logic [24:0] res_count_o,
  output logic [5:0]  best_center_o,
  output logic [6:0]  best_width_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [5:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int         WDW      = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [5:0] LAST_TAP = 6'(MAX_TAP);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_DLY, S_WR_INT, S_DWELL, S_RD_CNT, S_EVAL, S_WR_CTR, S_DONE
  } state_t;

  state_t      state_q;
  logic        busy_q, done_q, fail_q, res_valid_q;
  logic [5:0]  res_tap_q, best_center_q, tap_q, run_start_q;
  logic [24:0] res_count_q, count_q;
  logic [6:0]  best_width_q, run_len_q;
  logic        cyc_q, we_q;
  logic [5:0]  adr_q;
  logic [31:0] dat_q;
  logic [WDW-1:0] wd_q;
  logic [23:0] dwell_cnt_q;

  // Access fields for whichever bus state is about to issue
  logic        acc_we_d;
  logic [5:0]  acc_adr_d;
  logic [31:0] acc_dat_d;

  always_comb begin
    acc_we_d  = 1'b1;
    acc_adr_d = IDELAY_ADR;
    acc_dat_d = {26'd0, tap_q};
    case (state_q)
      S_WR_INT: begin
        acc_adr_d = BITERR_ADR;
        acc_dat_d = {8'd0, interval_i};
      end
      S_RD_CNT: begin
        acc_we_d  = 1'b0;
        acc_adr_d = BITERR_ADR;
        acc_dat_d = 32'd0;
      end
      S_WR_CTR: acc_dat_d = {26'd0, best_center_q};
      default: ;
    endcase
  end

  // Run tracking: a run closes on a failing tap or at the last tap
  logic       pass_d, last_tap_d, take_d;
  logic [6:0] cand_len_d, half_d, best_width_d;
  logic [5:0] cand_start_d, best_center_d;

  always_comb begin
    pass_d       = (count_q <= thresh_i);
    last_tap_d   = (tap_q == LAST_TAP);
    cand_len_d   = pass_d ? run_len_q + 7'd1 : run_len_q;
    cand_start_d = (pass_d && run_len_q == 7'd0) ? tap_q : run_start_q;
    half_d       = (cand_len_d - 7'd1) >> 1;
    take_d       = (!pass_d || last_tap_d) && (cand_len_d > best_width_q);
    best_width_d  = take_d ? cand_len_d : best_width_q;
    best_center_d = take_d ? cand_start_d + half_d[5:0] : best_center_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_tap_q     <= 6'd0;
      res_count_q   <= 25'd0;
      best_center_q <= 6'd0;
      best_width_q  <= 7'd0;
      tap_q         <= 6'd0;
      run_start_q   <= 6'd0;
      run_len_q     <= 7'd0;
      count_q       <= 25'd0;
      cyc_q         <= 1'b0;
      we_q          <= 1'b0;
      adr_q         <= 6'd0;
      dat_q         <= 32'd0;
      wd_q          <= '0;
      dwell_cnt_q   <= 24'd0;
    end else begin
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            busy_q        <= 1'b1;
            fail_q        <= 1'b0;
            best_center_q <= 6'd0;
            best_width_q  <= 7'd0;
            tap_q         <= 6'd0;
            run_start_q   <= 6'd0;
            run_len_q     <= 7'd0;
            state_q       <= S_WR_DLY;
          end
        end
        S_WR_DLY, S_WR_INT, S_RD_CNT, S_WR_CTR: begin
          // cyc low in a bus state always means the access has not been issued yet
          if (!cyc_q) begin
            cyc_q <= 1'b1;
            we_q  <= acc_we_d;
            adr_q <= acc_adr_d;
            dat_q <= acc_dat_d;
            wd_q  <= '0;
          end else if (wb_ack_i) begin
            cyc_q <= 1'b0;
            case (state_q)
              S_WR_DLY: state_q <= S_WR_INT;
              S_WR_INT: begin
                dwell_cnt_q <= 24'd0;
                state_q     <= (dwell_i == 24'd0) ? S_RD_CNT : S_DWELL;
              end
              S_RD_CNT: begin
                if (wb_dat_i[31:25] != 7'd0) begin
                  fail_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
                end else begin
                  count_q     <= wb_dat_i[24:0];
                  res_valid_q <= 1'b1;
                  res_tap_q   <= tap_q;
                  res_count_q <= wb_dat_i[24:0];
                  state_q     <= S_EVAL;
                end
              end
              default: begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
            endcase
          end else if (wb_err_i || wd_q == WD_LAST) begin
            cyc_q   <= 1'b0;
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_DWELL: begin
          if (dwell_cnt_q + 24'd1 >= dwell_i) state_q <= S_RD_CNT;
          else dwell_cnt_q <= dwell_cnt_q + 24'd1;
        end
        S_EVAL: begin
          best_width_q  <= best_width_d;
          best_center_q <= best_center_d;
          run_len_q     <= pass_d ? cand_len_d : 7'd0;
          run_start_q   <= cand_start_d;
          if (!last_tap_d) begin
            tap_q   <= tap_q + 6'd1;
            state_q <= S_WR_DLY;
          end else if (best_width_d == 7'd0) begin
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_WR_CTR;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign fail_o        = fail_q;
  assign res_valid_o   = res_valid_q;
  assign res_tap_o     = res_tap_q;
  assign res_count_o   = res_count_q;
  assign best_center_o = best_center_q;
  assign best_width_o  = best_width_q;
  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign wb_we_o       = we_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = dat_q;
  assign wb_sel_o      = 4'hF;

endmodule

// File: tb/tb_surfctl_eye_scan_master.sv
// Scoreboard bench for the eye-scan master: a model register target answers the bus,
// expected tap results are queued up front and popped by a monitor on each result pulse.
module tb_surfctl_eye_scan_master;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        start_i = 1'b0;
  logic [23:0] interval_i = 24'h00_1234;
  logic [23:0] dwell_i = 24'd3;
  logic [24:0] thresh_i = 25'd0;
  logic        busy_o, done_o, fail_o, res_valid_o;
  logic [5:0]  res_tap_o, best_center_o;
  logic [24:0] res_count_o;
  logic [6:0]  best_width_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [5:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = 32'd0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;

  always #5 clk = ~clk;

  surfctl_eye_scan_master dut (
    .wb_clk_i(clk), .wb_rst_i(srst), .start_i(start_i),
    .interval_i(interval_i), .dwell_i(dwell_i), .thresh_i(thresh_i),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
    .res_valid_o(res_valid_o), .res_tap_o(res_tap_o), .res_count_o(res_count_o),
    .best_center_o(best_center_o), .best_width_o(best_width_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Target model configuration
  int w1_lo, w1_hi, w2_lo, w2_hi;
  int pass_cnt, fail_cnt;
  int bad_tap = -1;
  bit noack = 1'b0;

  function automatic logic [31:0] tap_count(input int t);
    if ((t >= w1_lo && t <= w1_hi) || (t >= w2_lo && t <= w2_hi)) return 32'(pass_cnt);
    return 32'(fail_cnt);
  endfunction

  // Per-test observations
  int          n_acc, n_dly_wr, n_res, n_done, cyc_cycles;
  logic [31:0] last_dly_wr;
  logic [5:0]  cur_dly;
  logic [30:0] exp_q[$];

  always @(negedge clk) begin
    if (wb_cyc_o && wb_stb_o && !wb_ack_i && !(noack && wb_we_o)) begin
      wb_ack_i = 1'b1;
      n_acc++;
      if (wb_we_o) begin
        if (wb_adr_o == 6'h04) begin
          cur_dly     = wb_dat_o[5:0];
          last_dly_wr = wb_dat_o;
          n_dly_wr++;
        end
      end else if (wb_adr_o == 6'h08) begin
        wb_dat_i = (int'(cur_dly) == bad_tap) ? 32'hFFFF_FFFF : tap_count(int'(cur_dly));
      end else begin
        wb_dat_i = 32'd0;
      end
    end else begin
      wb_ack_i = 1'b0;
    end
  end

  // Monitor: compare each result pulse against the head of the scoreboard
  always @(negedge clk) begin
    if (wb_cyc_o) cyc_cycles++;
    if (done_o) n_done++;
    if (res_valid_o) begin
      logic [30:0] e;
      n_res++;
      if (exp_q.size() == 0) begin
        chk("res_unexpected", 32'(res_tap_o), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("res_tap", 32'(res_tap_o), 32'(e[30:25]));
        chk("res_count", 32'(res_count_o), 32'(e[24:0]));
      end
    end
  end

  task automatic config_scan(input int a_lo, input int a_hi, input int b_lo, input int b_hi,
                             input int pc, input int fc, input int bt, input bit na);
    logic [31:0] c;
    w1_lo = a_lo; w1_hi = a_hi; w2_lo = b_lo; w2_hi = b_hi;
    pass_cnt = pc; fail_cnt = fc; bad_tap = bt; noack = na;
    exp_q.delete();
    if (!na) begin
      for (int t = 0; t < 64; t++) begin
        if (bt >= 0 && t >= bt) break;
        c = tap_count(t);
        exp_q.push_back({6'(t), c[24:0]});
      end
    end
  endtask

  task automatic start_scan(input string name);
    n_acc = 0; n_dly_wr = 0; n_res = 0; n_done = 0; cyc_cycles = 0;
    last_dly_wr = 32'hDEAD_BEEF;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk({name, "_busy_after_start"}, 32'(busy_o), 32'd1);
    chk({name, "_fail_cleared"}, 32'(fail_o), 32'd0);
  endtask

  task automatic finish_scan(input string name, input bit exp_fail, input int exp_w,
                             input int exp_c, input int exp_nres);
    bit seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        chk({name, "_busy_at_done"}, 32'(busy_o), 32'd0);
        break;
      end
    end
    if (!seen) chk({name, "_done_timeout"}, 32'd0, 32'd1);
    repeat (30) @(negedge clk);
    chk({name, "_done_count"}, 32'(n_done), 32'd1);
    chk({name, "_fail"}, 32'(fail_o), 32'(exp_fail));
    chk({name, "_best_width"}, 32'(best_width_o), 32'(exp_w));
    chk({name, "_best_center"}, 32'(best_center_o), 32'(exp_c));
    chk({name, "_n_results"}, 32'(n_res), 32'(exp_nres));
    chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc_snap;
    repeat (3) @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_fail", 32'(fail_o), 32'd0);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_sel", 32'(wb_sel_o), 32'hF);
    chk("rst_width", 32'(best_width_o), 32'd0);

    // Single window 20..35: width 16, centre 20 + 7 = 27
    dwell_i = 24'd3; thresh_i = 25'd0;
    config_scan(20, 35, 1, 0, 0, 500, -1, 1'b0);
    start_scan("win16");
    finish_scan("win16", 1'b0, 16, 27, 64);
    chk("win16_final_dly", last_dly_wr, 32'd27);
    chk("win16_dly_writes", 32'(n_dly_wr), 32'd65);
    $display("scan win16: width=%0d centre=%0d fail=%0d", best_width_o, best_center_o, fail_o);

    // Two equal windows, count == thresh passes: first window kept, centre 7
    dwell_i = 24'd0; thresh_i = 25'd100;
    config_scan(5, 9, 40, 44, 100, 101, -1, 1'b0);
    start_scan("tie");
    finish_scan("tie", 1'b0, 5, 7, 64);
    chk("tie_final_dly", last_dly_wr, 32'd7);
    $display("scan tie: width=%0d centre=%0d fail=%0d", best_width_o, best_center_o, fail_o);

    // No passing tap: no centre write, IDELAY left at 63
    dwell_i = 24'd1; thresh_i = 25'd0;
    config_scan(1, 0, 1, 0, 0, 100, -1, 1'b0);
    start_scan("nowin");
    finish_scan("nowin", 1'b1, 0, 0, 64);
    chk("nowin_final_dly", last_dly_wr, 32'd63);
    chk("nowin_dly_writes", 32'(n_dly_wr), 32'd64);
    $display("scan nowin: width=%0d fail=%0d last_dly=%0d", best_width_o, fail_o, last_dly_wr);

    // All-ones read at tap 3: abort after 3 results and 12 accesses
    dwell_i = 24'd2; thresh_i = 25'd0;
    config_scan(20, 35, 1, 0, 0, 500, 3, 1'b0);
    start_scan("baddat");
    finish_scan("baddat", 1'b1, 0, 0, 3);
    acc_snap = n_acc;
    repeat (50) @(negedge clk);
    chk("baddat_accesses", 32'(n_acc), 32'd12);
    chk("baddat_quiet", 32'(n_acc), 32'(acc_snap));
    $display("scan baddat: results=%0d accesses=%0d fail=%0d", n_res, n_acc, fail_o);

    // Target never acks writes: watchdog drops cyc after 1023 cycles
    config_scan(20, 35, 1, 0, 0, 500, -1, 1'b1);
    start_scan("noack");
    finish_scan("noack", 1'b1, 0, 0, 0);
    chk("noack_cyc_cycles", 32'(cyc_cycles), 32'd1023);
    chk("noack_cyc_low", 32'(wb_cyc_o), 32'd0);
    $display("scan noack: cyc_cycles=%0d fail=%0d", cyc_cycles, fail_o);

    // Reset during DWELL, then a fresh scan from tap 0
    dwell_i = 24'd1000; thresh_i = 25'd0;
    config_scan(20, 35, 1, 0, 0, 500, -1, 1'b0);
    start_scan("rstmid");
    for (int i = 0; i < 200 && n_acc < 2; i++) @(negedge clk);
    chk("rstmid_reached_dwell", 32'(n_acc), 32'd2);
    repeat (5) @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    chk("rstmid_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rstmid_busy", 32'(busy_o), 32'd0);
    srst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rstmid_no_done", 32'(n_done), 32'd0);
    chk("rstmid_no_more_acc", 32'(n_acc), 32'd2);
    $display("reset mid-dwell: cyc=%0d busy=%0d done_pulses=%0d", wb_cyc_o, busy_o, n_done);

    dwell_i = 24'd3;
    config_scan(20, 35, 1, 0, 0, 500, -1, 1'b0);
    start_scan("rescan");
    finish_scan("rescan", 1'b0, 16, 27, 64);
    chk("rescan_final_dly", last_dly_wr, 32'd27);
    $display("scan rescan: width=%0d centre=%0d fail=%0d", best_width_o, best_center_o, fail_o);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
